fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the controller/datapath. Owns the fetch PC,
//  issues in-order word reads to instruction memory, buffers returned words in a small prefetch
//  FIFO and presents {Instr, PC, PC+8} to decode. A taken branch or PC write (PCSrc) flushes
//  the FIFO, discards in-flight responses and restarts fetch at the new target.
// PARAMETERS
//  RESET_PC  32'h0000_0000  First fetch address after reset
//  DEPTH     4              Prefetch FIFO entries, power of 2, 2..16; also max outstanding+buffered
// PORTS
//  clk          in   1   Clock; all state on rising edge
//  reset        in   1   Asynchronous, active-low reset (reset==0 clears all state)
//  imem_req     out  1   Read request valid
//  imem_addr    out  32  Request address, word aligned ([1:0]==0)
//  imem_gnt     in   1   Memory accepts the request this cycle (req&&gnt = issue)
//  imem_rvalid  in   1   Read data valid; responses in issue order, >=1 cycle after grant
//  imem_rdata   in   32  Read data
//  redirect     in   1   PCSrc from controller: flush and refetch
//  redirect_pc  in   32  New PC (Result); bits [1:0] forced to 0
//  instr_ready  in   1   Decode consumes the head entry this cycle
//  instr_valid  out  1   Head entry valid
//  instr        out  32  Head instruction; 32'hE1A0_0000 (MOV r0,r0 NOP) when !instr_valid
//  instr_pc     out  32  Address of head instruction (0 when !instr_valid)
//  pc_plus8     out  32  instr_pc + 8 (ARM R15 read value), mod 2^32
// BEHAVIOUR
//  - States: RUN, DRAIN. Reset -> RUN, fetch_pc=RESET_PC, FIFO empty, outstanding=0,
//    imem_req=0, instr_valid=0, instr=NOP. First request in first cycle after reset release.
//  - credit = (outstanding + fifo_count) < DEPTH. imem_req = (state==RUN) && credit && !redirect.
//  - Issue (req&&gnt): outstanding+1, fetch_pc += 4 (wraps at 2^32). No issue without gnt; addr held.
//  - rvalid in RUN: push {rdata, resp_pc} into FIFO, outstanding-1, resp_pc += 4. Entry visible on
//    instr_valid the cycle after rvalid (no bypass). rvalid with outstanding==0 is a protocol
//    error: ignored (assertion in sim).
//  - Pop when instr_valid && instr_ready. Push and pop in the same cycle allowed at any count.
//  - redirect (level, sampled each cycle): FIFO cleared next cycle, pop that cycle suppressed,
//    fetch_pc=resp_pc=redirect_pc&~3. If outstanding>0 (after counting this cycle's rvalid)
//    -> DRAIN, else stay RUN.
//  - DRAIN: no requests; each rvalid discarded, outstanding-1; at outstanding==0 -> RUN next cycle.
//    redirect in DRAIN: update target, stay DRAIN.
//  - Outstanding counter width clog2(DEPTH)+1; never exceeds DEPTH by construction.
//  - Async reset at any point (incl. DRAIN) returns to reset state; later stale rvalid ignored.
// CONFIGURATION
//  FETCH_PERF_EN defined: extra outputs perf_fetched[31:0] (count of FIFO pops) and
//    perf_flushes[15:0] (count of redirect cycles), both saturating, cleared by reset.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  fetch_pkg: FETCH_NOP=32'hE1A0_0000; fetch_state_t enum {RUN, DRAIN};
//    fetch_entry_t struct {logic [31:0] instr; logic [31:0] pc;}.
//  Sub-module fetch_fifo (DEPTH, fetch_entry_t): push/pop/flush, count, head, sync clear.
//  Top holds FSM, fetch_pc, resp_pc, outstanding counter, output muxing, optional perf counters.
// TESTING
//  1 reset=0 for 3 cycles -> imem_req=0, instr_valid=0, instr=E1A00000; release -> req=1, addr=0x0.
//  2 gnt=1 always, rvalid 1 cycle after gnt, ready=1 -> instr_pc 0x0,0x4,0x8.. one/cycle,
//    pc_plus8=instr_pc+8, instr matches rdata order.
//  3 DEPTH=4, ready=0 -> exactly 4 grants (0x0..0xC) then req=0; ready=1 -> next req addr 0x10.
//  4 2 outstanding, redirect=1 with redirect_pc=0x103 -> FIFO empty next cycle, state DRAIN,
//    2 responses dropped, then req addr 0x100; first valid instr_pc=0x100.
//  5 redirect with instr_valid&&instr_ready same cycle -> no pop counted (perf_fetched unchanged),
//    perf_flushes +1 under FETCH_PERF_EN; gnt low 3 cycles -> addr held stable.
//  6 reset asserted mid-DRAIN with 1 outstanding -> after release req addr=RESET_PC; stray rvalid
//    ignored, instr_valid stays 0 until the new response.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch stage
package fetch_pkg;
  localparam logic [31:0] FETCH_NOP = 32'hE1A0_0000;
  typedef enum logic {RUN, DRAIN} fetch_state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer of fetched {instr, pc} entries with synchronous flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push);
      rd_q  <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_q] <= push_data;
  assign count = cnt_q;
  assign head  = mem[rd_q];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, in-order imem reads, prefetch FIFO and redirect/drain handling
// Define FETCH_PERF_EN to add the perf_fetched/perf_flushes saturating counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus8
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [15:0] perf_flushes
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
  logic [CW-1:0] out_q, out_d, count;
  fetch_entry_t head;
  logic issue, rsp, push, pop;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data ('{instr: imem_rdata, pc: resp_pc_q}),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );
  // Outstanding plus buffered never exceeds DEPTH, so every response has a FIFO slot.
  always_comb begin
    target     = {redirect_pc[31:2], 2'b00};
    imem_req   = reset && state_q == RUN && (out_q + count) < CW'(DEPTH) && !redirect;
    issue      = imem_req && imem_gnt;
    rsp        = imem_rvalid && out_q != '0;
    push       = rsp && state_q == RUN && !redirect;
    pop        = instr_valid && instr_ready && !redirect;
    out_d      = out_q + CW'(issue) - CW'(rsp);
    fetch_pc_d = redirect ? target : issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d  = redirect ? target : push ? resp_pc_q + 32'd4 : resp_pc_q;
    state_d    = (redirect || state_q == DRAIN) ? (out_d != '0 ? DRAIN : RUN) : RUN;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
    end
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = count != '0;
  assign instr       = instr_valid ? head.instr : FETCH_NOP;
  assign instr_pc    = instr_valid ? head.pc : 32'h0;
  assign pc_plus8    = instr_pc + 32'd8;
`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q;
  logic [15:0] flushes_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fetched_q <= '0;
      flushes_q <= '0;
    end else begin
      if (pop && fetched_q != '1) fetched_q <= fetched_q + 32'd1;
      if (redirect && flushes_q != '1) flushes_q <= flushes_q + 16'd1;
    end
  assign perf_fetched = fetched_q;
  assign perf_flushes = flushes_q;
`endif
  rvalid_has_outstanding: assert property (@(posedge clk) disable iff (!reset) imem_rvalid |-> out_q != '0);
endmodule
